branch_sequencer: RTL and testbench
===================================

# branch_sequencer

Program-counter sequencer for the next-address stage: latches the ALU condition flags, resolves conditional branches, jumps, calls and returns, and drives the fetch PC. It owns the branch-condition evaluation (8-way brType encoding) and a small return-address stack. It tells the front end to squash wrong-path instructions after every redirect.

## Interface
- AW, default 16: PC / target width
- RESET_PC, default 0: PC value after reset
- STACK_DEPTH, default 4: return-stack entries (power of 2, ≥2)
- FLUSH_CYCLES, default 2: squash cycles after a redirect (≥1)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- stall  in  1  freeze PC, FSM, stack and flush counter
- flag_we  in  1  load flag register from z_in/cy_in/s_in/v_in
- z_in, cy_in, s_in, v_in  in  1 each  ALU flags
- instr_valid  in  1  op/br_type/target valid this cycle
- op  in  3  000 seq, 001 cond branch, 010 jump, 011 call, 100 return, others = seq
- br_type  in  3  000 bnz, 001 bncy, 010 bns, 011 bnv, 100 bz, 101 bcy, 110 bs, 111 bv
- target  in  AW  absolute destination
- pc  out  AW  current fetch address (registered)
- flush  out  1  squash wrong-path instructions (registered)
- flags  out  4  {v,s,cy,z} flag register
- stack_err  out  1  sticky: overflow or underflow occurred

## Operation
- Reset: pc=RESET_PC, flags=0, flush=0, stack empty (sp=0), stack_err=0, state RUN.
- Flag register: loaded on any edge with flag_we=1, including during stall and FLUSH. Branch evaluation uses the registered value. flag_we coincident with a branch does not affect that branch.
- Condition: sel = br_type[1:0] picks z/cy/s/v. taken = (flag == br_type[2]).
- FSM RUN: an op is accepted when instr_valid=1 and stall=0.
  - seq, or not taken: pc<=pc+1 (wraps modulo 2^AW).
  - taken branch / jump: pc<=target, go FLUSH.
  - call: push pc+1, pc<=target, go FLUSH. If stack full: no push, stack_err<=1, jump still taken.
  - return: pop, pc<=popped value, go FLUSH. If empty: stack_err<=1, no redirect, pc<=pc+1, stay RUN.
- FSM FLUSH: flush=1. instr_valid/op ignored. pc<=pc+1 each unstalled cycle. Counter runs from FLUSH_CYCLES-1 to 0, then returns to RUN.
- No instr_valid in RUN: pc<=pc+1 (free-running fetch).
- stall=1: pc, state, counter and stack hold. flush holds its value. Flags may still update.
- stack_err is cleared only by reset.

## Timing
- Decision is combinational from the registered flags and inputs. The redirect takes effect on the same edge that accepts the op.
- Redirect accepted at edge k: pc=target from cycle k+1. flush=1 for cycles k+1 .. k+FLUSH_CYCLES (stall cycles extend this). First op accepted again at edge k+FLUSH_CYCLES+1.
- Call pushes at the accepting edge. A return can pop that entry at the first RUN cycle after the flush.
- Asynchronous reset mid-FLUSH or mid-stall immediately forces all reset values. Reset release is synchronous to clk by the system.

## Test plan
- Reset with RESET_PC=16'h0100, then 3 idle cycles -> pc 0100,0101,0102,0103. flush=0, stack_err=0.
- flag_we with z_in=1. Next cycle cond branch br_type=100, target=0x0040 -> pc=0x0040 next cycle, flush=1 for exactly 2 cycles. Repeat with br_type=000 -> not taken, pc+1, flush stays 0.
- Branch bcy in the same cycle as flag_we with cy_in=1, old cy=0 -> not taken. The same branch one cycle later -> taken.
- call target=0x0200 at pc=0x0010, wait out the flush, return -> pc=0x0011, flush pulse. Then 5 calls with depth 4 -> stack_err=1 on the 5th, pc=target still. Then 5 returns -> the 5th sets stack_err again and pc increments.
- stall=1 for 3 cycles during FLUSH -> pc and flush frozen, flush total high cycles = 2+3. Ops presented during flush ignored.
- pc=0xFFFF, seq -> pc wraps to 0x0000. Assert rst_n low mid-FLUSH -> pc=RESET_PC, flush=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/branch_sequencer.sv
// Next-address PC sequencer: flag register, 8-way branch condition, return stack,
// and a post-redirect squash window.
module branch_sequencer #(
    parameter int              AW           = 16,
    parameter logic [AW-1:0]   RESET_PC     = '0,
    parameter int              STACK_DEPTH  = 4,
    parameter int              FLUSH_CYCLES = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          stall,
    input  logic          flag_we,
    input  logic          z_in,
    input  logic          cy_in,
    input  logic          s_in,
    input  logic          v_in,
    input  logic          instr_valid,
    input  logic [2:0]    op,
    input  logic [2:0]    br_type,
    input  logic [AW-1:0] target,
    output logic [AW-1:0] pc,
    output logic          flush,
    output logic [3:0]    flags,
    output logic          stack_err
);

    localparam int SPW = $clog2(STACK_DEPTH) + 1;
    localparam int CW  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(FLUSH_CYCLES - 1);

    localparam logic [2:0] OP_COND = 3'b001;
    localparam logic [2:0] OP_JUMP = 3'b010;
    localparam logic [2:0] OP_CALL = 3'b011;
    localparam logic [2:0] OP_RET  = 3'b100;

    typedef enum logic {ST_RUN, ST_FLUSH} state_t;

    state_t          r_state;
    logic [AW-1:0]   r_pc;
    logic            r_flush;
    logic [3:0]      r_flags;
    logic            r_err;
    logic [CW-1:0]   r_cnt;
    logic [SPW-1:0]  r_sp;
    logic [AW-1:0]   r_stack [STACK_DEPTH];

    logic            w_taken;
    logic            w_full;
    logic            w_empty;
    logic [SPW-2:0]  w_pop_idx;
    logic [AW-1:0]   w_pc_inc;
    logic            w_redirect;
    logic [AW-1:0]   w_redirect_pc;
    logic            w_push;
    logic            w_pop;
    logic            w_err_set;

    assign w_taken   = (r_flags[br_type[1:0]] == br_type[2]);
    assign w_full    = (r_sp == SPW'(STACK_DEPTH));
    assign w_empty   = (r_sp == '0);
    assign w_pop_idx = r_sp[SPW-2:0] - (SPW-1)'(1);
    assign w_pc_inc  = r_pc + AW'(1);

    // Op decode is only meaningful in RUN with an unstalled, valid instruction.
    always_comb begin
        w_redirect    = 1'b0;
        w_redirect_pc = target;
        w_push        = 1'b0;
        w_pop         = 1'b0;
        w_err_set     = 1'b0;
        if (r_state == ST_RUN && instr_valid && !stall) begin
            case (op)
                OP_COND: w_redirect = w_taken;
                OP_JUMP: w_redirect = 1'b1;
                OP_CALL: begin
                    w_redirect = 1'b1;
                    w_push     = !w_full;
                    w_err_set  = w_full;
                end
                OP_RET: begin
                    w_redirect    = !w_empty;
                    w_pop         = !w_empty;
                    w_err_set     = w_empty;
                    w_redirect_pc = r_stack[w_pop_idx];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
            r_pc    <= RESET_PC;
            r_flush <= 1'b0;
            r_flags <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
            r_sp    <= '0;
            for (int i = 0; i < STACK_DEPTH; i++) r_stack[i] <= '0;
        end else begin
            if (flag_we) r_flags <= {v_in, s_in, cy_in, z_in};
            if (w_err_set) r_err <= 1'b1;
            if (w_push) begin
                r_stack[r_sp[SPW-2:0]] <= w_pc_inc;
                r_sp <= r_sp + SPW'(1);
            end else if (w_pop) begin
                r_sp <= r_sp - SPW'(1);
            end
            if (!stall) begin
                case (r_state)
                    ST_RUN: begin
                        if (w_redirect) begin
                            r_pc    <= w_redirect_pc;
                            r_state <= ST_FLUSH;
                            r_flush <= 1'b1;
                            r_cnt   <= CNT_INIT;
                        end else begin
                            r_pc <= w_pc_inc;
                        end
                    end
                    ST_FLUSH: begin
                        r_pc <= w_pc_inc;
                        if (r_cnt == '0) begin
                            r_state <= ST_RUN;
                            r_flush <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt - CW'(1);
                        end
                    end
                    default: r_state <= ST_RUN;
                endcase
            end
        end
    end

    assign pc        = r_pc;
    assign flush     = r_flush;
    assign flags     = r_flags;
    assign stack_err = r_err;

endmodule

// File: tb/tb_branch_sequencer.sv
// Self-checking bench for branch_sequencer: directed vector table, hand-written
// corner sequences, and randomized traffic against a queue-based reference model.
module tb_branch_sequencer;

    localparam int          AW  = 16;
    localparam logic [15:0] RST = 16'h0100;
    localparam int          SD  = 4;
    localparam int          FC  = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, flag_we, z_in, cy_in, s_in, v_in, instr_valid;
    logic [2:0]  op, br_type;
    logic [15:0] target;
    logic [15:0] pc;
    logic        flush;
    logic [3:0]  flags;
    logic        stack_err;

    int total = 0;
    int bad   = 0;

    branch_sequencer #(.AW(AW), .RESET_PC(RST), .STACK_DEPTH(SD), .FLUSH_CYCLES(FC)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flag_we(flag_we),
        .z_in(z_in), .cy_in(cy_in), .s_in(s_in), .v_in(v_in),
        .instr_valid(instr_valid), .op(op), .br_type(br_type), .target(target),
        .pc(pc), .flush(flush), .flags(flags), .stack_err(stack_err)
    );

    always #5 clk = ~clk;

    // Reference model: flush tracked as cycles remaining, stack as a queue.
    logic [15:0] m_pc;
    logic [3:0]  m_flags;
    int          m_flush_left;
    logic [15:0] m_stack [$];
    logic        m_err;

    task automatic model_reset();
        m_pc = RST;
        m_flags = 4'h0;
        m_flush_left = 0;
        m_stack.delete();
        m_err = 1'b0;
    endtask

    task automatic model_edge();
        logic [3:0] old_flags;
        old_flags = m_flags;
        if (flag_we) m_flags = {v_in, s_in, cy_in, z_in};
        if (!stall) begin
            if (m_flush_left > 0) begin
                m_pc = m_pc + 16'd1;
                m_flush_left--;
            end else if (instr_valid && op == 3'd1 && (old_flags[br_type[1:0]] == br_type[2])) begin
                m_pc = target;
                m_flush_left = FC;
            end else if (instr_valid && op == 3'd2) begin
                m_pc = target;
                m_flush_left = FC;
            end else if (instr_valid && op == 3'd3) begin
                if (m_stack.size() < SD) m_stack.push_back(m_pc + 16'd1);
                else m_err = 1'b1;
                m_pc = target;
                m_flush_left = FC;
            end else if (instr_valid && op == 3'd4 && m_stack.size() > 0) begin
                m_pc = m_stack.pop_back();
                m_flush_left = FC;
            end else begin
                if (instr_valid && op == 3'd4) m_err = 1'b1;
                m_pc = m_pc + 16'd1;
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".pc"},    32'(pc),        32'(m_pc));
        chk({tag, ".flush"}, 32'(flush),     32'(m_flush_left > 0));
        chk({tag, ".flags"}, 32'(flags),     32'(m_flags));
        chk({tag, ".err"},   32'(stack_err), 32'(m_err));
    endtask

    task automatic step(input logic s, input logic fwe, input logic [3:0] fin, input logic iv,
                        input logic [2:0] o, input logic [2:0] b, input logic [15:0] t,
                        input string tag);
        stall = s; flag_we = fwe;
        z_in = fin[0]; cy_in = fin[1]; s_in = fin[2]; v_in = fin[3];
        instr_valid = iv; op = o; br_type = b; target = t;
        @(posedge clk);
        model_edge();
        #1;
        chk_model(tag);
    endtask

    task automatic idle(input string tag);
        step(1'b0, 1'b0, 4'h0, 1'b0, 3'd0, 3'd0, 16'h0, tag);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        stall = 1'b0; flag_we = 1'b0; z_in = 1'b0; cy_in = 1'b0; s_in = 1'b0; v_in = 1'b0;
        instr_valid = 1'b0; op = 3'd0; br_type = 3'd0; target = 16'h0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("reset.pc", 32'(pc), 32'(RST));
        chk("reset.flush", 32'(flush), 32'd0);
        chk("reset.err", 32'(stack_err), 32'd0);
        chk("reset.flags", 32'(flags), 32'd0);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic        s;
        logic        fwe;
        logic [3:0]  fin;
        logic        iv;
        logic [2:0]  o;
        logic [2:0]  b;
        logic [15:0] t;
        logic [15:0] epc;
        logic        efl;
        logic [3:0]  efg;
    } vec_t;

    localparam int NV = 27;
    vec_t tbl [NV];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] exp_ret [5];
        logic [15:0] pc_before;
        string       tag;

        tbl[0]  = '{1'b0, 1'b0, 4'h0, 1'b0, 3'd0, 3'd0, 16'h0000, 16'h0101, 1'b0, 4'h0};
        tbl[1]  = '{1'b0, 1'b0, 4'h0, 1'b0, 3'd0, 3'd0, 16'h0000, 16'h0102, 1'b0, 4'h0};
        tbl[2]  = '{1'b0, 1'b0, 4'h0, 1'b0, 3'd0, 3'd0, 16'h0000, 16'h0103, 1'b0, 4'h0};
        tbl[3]  = '{1'b0, 1'b1, 4'h1, 1'b0, 3'd0, 3'd0, 16'h0000, 16'h0104, 1'b0, 4'h1};
        tbl[4]  = '{1'b0, 1'b0, 4'h0, 1'b1, 3'd1, 3'd4, 16'h0040, 16'h0040, 1'b1, 4'h1};
        tbl[5]  = '{1'b0, 1'b0, 4'h0, 1'b0, 3'd0, 3'd0, 16'h0000, 16'h0041, 1'b1, 4'h1};
        tbl[6]  = '{1'b0, 1'b0, 4'h0, 1'b0, 3'd0, 3'd0, 16'h0000, 16'h0042, 1'b0, 4'h1};
        tbl[7]  = '{1'b0, 1'b0, 4'h0, 1'b1, 3'd1, 3'd0, 16'h0040, 16'h0043, 1'b0, 4'h1};
        tbl[8]  = '{1'b0, 1'b1, 4'h3, 1'b1, 3'd1, 3'd5, 16'h0080, 16'h0044, 1'b0, 4'h3};
        tbl[9]  = '{1'b0, 1'b0, 4'h0, 1'b1, 3'd1, 3'd5, 16'h0080, 16'h0080, 1'b1, 4'h3};
        tbl[10] = '{1'b0, 1'b0, 4'h0, 1'b0, 3'd0, 3'd0, 16'h0000, 16'h0081, 1'b1, 4'h3};
        tbl[11] = '{1'b0, 1'b0, 4'h0, 1'b0, 3'd0, 3'd0, 16'h0000, 16'h0082, 1'b0, 4'h3};
        tbl[12] = '{1'b0, 1'b0, 4'h0, 1'b1, 3'd2, 3'd0, 16'h000E, 16'h000E, 1'b1, 4'h3};
        tbl[13] = '{1'b0, 1'b0, 4'h0, 1'b0, 3'd0, 3'd0, 16'h0000, 16'h000F, 1'b1, 4'h3};
        tbl[14] = '{1'b0, 1'b0, 4'h0, 1'b0, 3'd0, 3'd0, 16'h0000, 16'h0010, 1'b0, 4'h3};
        tbl[15] = '{1'b0, 1'b0, 4'h0, 1'b1, 3'd3, 3'd0, 16'h0200, 16'h0200, 1'b1, 4'h3};
        tbl[16] = '{1'b0, 1'b0, 4'h0, 1'b0, 3'd0, 3'd0, 16'h0000, 16'h0201, 1'b1, 4'h3};
        tbl[17] = '{1'b0, 1'b0, 4'h0, 1'b0, 3'd0, 3'd0, 16'h0000, 16'h0202, 1'b0, 4'h3};
        tbl[18] = '{1'b0, 1'b0, 4'h0, 1'b1, 3'd4, 3'd0, 16'h0000, 16'h0011, 1'b1, 4'h3};
        tbl[19] = '{1'b0, 1'b0, 4'h0, 1'b0, 3'd0, 3'd0, 16'h0000, 16'h0012, 1'b1, 4'h3};
        tbl[20] = '{1'b0, 1'b0, 4'h0, 1'b0, 3'd0, 3'd0, 16'h0000, 16'h0013, 1'b0, 4'h3};
        tbl[21] = '{1'b0, 1'b0, 4'h0, 1'b1, 3'd2, 3'd0, 16'h0300, 16'h0300, 1'b1, 4'h3};
        tbl[22] = '{1'b1, 1'b0, 4'h0, 1'b1, 3'd2, 3'd0, 16'h0500, 16'h0300, 1'b1, 4'h3};
        tbl[23] = '{1'b1, 1'b0, 4'h0, 1'b1, 3'd2, 3'd0, 16'h0500, 16'h0300, 1'b1, 4'h3};
        tbl[24] = '{1'b1, 1'b0, 4'h0, 1'b1, 3'd2, 3'd0, 16'h0500, 16'h0300, 1'b1, 4'h3};
        tbl[25] = '{1'b0, 1'b0, 4'h0, 1'b1, 3'd2, 3'd0, 16'h0500, 16'h0301, 1'b1, 4'h3};
        tbl[26] = '{1'b0, 1'b0, 4'h0, 1'b0, 3'd0, 3'd0, 16'h0000, 16'h0302, 1'b0, 4'h3};

        do_reset();

        for (int i = 0; i < NV; i++) begin
            tag = $sformatf("vec%0d", i);
            step(tbl[i].s, tbl[i].fwe, tbl[i].fin, tbl[i].iv, tbl[i].o, tbl[i].b, tbl[i].t, tag);
            chk({tag, ".tbl_pc"},    32'(pc),    32'(tbl[i].epc));
            chk({tag, ".tbl_flush"}, 32'(flush), 32'(tbl[i].efl));
            chk({tag, ".tbl_flags"}, 32'(flags), 32'(tbl[i].efg));
        end

        // Five calls into a four-deep stack: the last overflows but still jumps.
        for (int i = 0; i < 5; i++) begin
            exp_ret[i] = m_pc + 16'd1;
            step(1'b0, 1'b0, 4'h0, 1'b1, 3'd3, 3'd0, 16'h1000 + 16'(i * 16), $sformatf("call%0d", i));
            chk($sformatf("call%0d.target", i), 32'(pc), 32'(16'h1000 + 16'(i * 16)));
            chk($sformatf("call%0d.err", i), 32'(stack_err), 32'(i == 4));
            idle("call_fl1");
            idle("call_fl2");
        end

        // Five returns: four pop in LIFO order, the fifth underflows.
        for (int i = 0; i < 5; i++) begin
            pc_before = m_pc;
            step(1'b0, 1'b0, 4'h0, 1'b1, 3'd4, 3'd0, 16'h0, $sformatf("ret%0d", i));
            if (i < 4) begin
                chk($sformatf("ret%0d.pc", i), 32'(pc), 32'(exp_ret[3 - i]));
                chk($sformatf("ret%0d.flush", i), 32'(flush), 32'd1);
                idle("ret_fl1");
                idle("ret_fl2");
            end else begin
                chk("ret_under.pc", 32'(pc), 32'(pc_before + 16'd1));
                chk("ret_under.flush", 32'(flush), 32'd0);
                chk("ret_under.err", 32'(stack_err), 32'd1);
            end
        end

        // PC wrap at the top of the address space.
        step(1'b0, 1'b0, 4'h0, 1'b1, 3'd2, 3'd0, 16'hFFFD, "wrap_j");
        idle("wrap_f1");
        idle("wrap_f2");
        chk("wrap.pre", 32'(pc), 32'h0000FFFF);
        step(1'b0, 1'b0, 4'h0, 1'b1, 3'd0, 3'd0, 16'h0, "wrap_seq");
        chk("wrap.pc", 32'(pc), 32'h00000000);

        // Asynchronous reset in the middle of a flush window.
        step(1'b0, 1'b0, 4'h0, 1'b1, 3'd2, 3'd0, 16'h0700, "ar_j");
        chk("ar.pre_flush", 32'(flush), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar.pc", 32'(pc), 32'(RST));
        chk("ar.flush", 32'(flush), 32'd0);
        chk("ar.err", 32'(stack_err), 32'd0);
        do_reset();

        // Underflow alone, from a freshly reset stack.
        step(1'b0, 1'b0, 4'h0, 1'b1, 3'd4, 3'd0, 16'h0, "uf");
        chk("uf.pc", 32'(pc), 32'(RST + 16'd1));
        chk("uf.err", 32'(stack_err), 32'd1);

        // Randomized traffic in three reset-separated blocks.
        for (int blk = 0; blk < 3; blk++) begin
            do_reset();
            for (int n = 0; n < 250; n++) begin
                step(($urandom % 8) == 0, ($urandom % 3) == 0, 4'($urandom),
                     ($urandom % 4) != 0, 3'($urandom_range(0, 7)), 3'($urandom),
                     16'($urandom), "rnd");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
